// File: rtl/spike_window_counter.sv
// Counts spike events per channel over back-to-back windows of win_len+1 cycles and
// presents the latched counts with a valid/ready handshake. Optional macro: SPIKE_EDGE_DETECT_EN.
module spike_window_counter #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       spike_in,
  input  logic [WIN_W-1:0]        win_len,
  output logic [NUM_CH*CNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]       sat_out,
  output logic                    count_valid,
  input  logic                    count_ready,
  output logic                    overrun,
  output logic                    busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0] CYC_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  state_t                    state_r;
  logic [WIN_W-1:0]          cyc_r;
  logic [WIN_W-1:0]          len_r;
  logic [NUM_CH*CNT_W-1:0]   cnt_r;
  logic [NUM_CH-1:0]         ev_s;
  logic [NUM_CH*CNT_W-1:0]   cnt_nxt_s;
  logic [NUM_CH-1:0]         sat_nxt_s;
  logic                      win_end_s;
  logic                      consume_s;

`ifdef SPIKE_EDGE_DETECT_EN
  logic [NUM_CH-1:0] spike_q_r;

  // Previous-cycle spike levels, tracked in every state so edges are seen at window start.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q_r <= {NUM_CH{1'b0}};
    end else begin
      spike_q_r <= spike_in;
    end
  end

  // Event = rising edge while counting.
  always_comb begin
    ev_s = {NUM_CH{1'b0}};
    if (state_r == ST_COUNT) begin
      ev_s = spike_in & ~spike_q_r;
    end else begin
      ev_s = {NUM_CH{1'b0}};
    end
  end
`else
  // Event = any high cycle while counting.
  always_comb begin
    ev_s = {NUM_CH{1'b0}};
    if (state_r == ST_COUNT) begin
      ev_s = spike_in;
    end else begin
      ev_s = {NUM_CH{1'b0}};
    end
  end
`endif

  // Saturating per-channel increment; the sat flag reflects a count pinned at its maximum.
  always_comb begin
    cnt_nxt_s = cnt_r;
    sat_nxt_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (ev_s[k] && (cnt_r[k*CNT_W +: CNT_W] != CNT_MAX)) begin
        cnt_nxt_s[k*CNT_W +: CNT_W] = cnt_r[k*CNT_W +: CNT_W] + CNT_ONE;
      end else begin
        cnt_nxt_s[k*CNT_W +: CNT_W] = cnt_r[k*CNT_W +: CNT_W];
      end
      sat_nxt_s[k] = (cnt_nxt_s[k*CNT_W +: CNT_W] == CNT_MAX);
    end
  end

  // Window-end and handshake-consume strobes.
  always_comb begin
    win_end_s = 1'b0;
    consume_s = count_valid & count_ready;
    if (state_r == ST_COUNT) begin
      win_end_s = (cyc_r == len_r);
    end else begin
      win_end_s = 1'b0;
    end
  end

  // Window FSM with registered result, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cyc_r       <= {WIN_W{1'b0}};
      len_r       <= {WIN_W{1'b0}};
      cnt_r       <= {(NUM_CH*CNT_W){1'b0}};
      count_out   <= {(NUM_CH*CNT_W){1'b0}};
      sat_out     <= {NUM_CH{1'b0}};
      count_valid <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // A consume clears valid unless a new result lands in the same cycle (below).
      if (consume_s) begin
        count_valid <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (en) begin
            state_r <= ST_COUNT;
            busy    <= 1'b1;
            len_r   <= win_len;
            cyc_r   <= {WIN_W{1'b0}};
            cnt_r   <= {(NUM_CH*CNT_W){1'b0}};
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            cyc_r   <= {WIN_W{1'b0}};
            cnt_r   <= {(NUM_CH*CNT_W){1'b0}};
          end else if (win_end_s) begin
            count_out   <= cnt_nxt_s;
            sat_out     <= sat_nxt_s;
            count_valid <= 1'b1;
            if (count_valid && !count_ready) begin
              overrun <= 1'b1;
            end
            len_r <= win_len;
            cyc_r <= {WIN_W{1'b0}};
            cnt_r <= {(NUM_CH*CNT_W){1'b0}};
          end else begin
            cyc_r <= cyc_r + CYC_ONE;
            cnt_r <= cnt_nxt_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_window_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared every cycle
// against a window-level reference model (event tallies as plain integers).
module tb_spike_window_counter;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int WIN_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [NUM_CH-1:0]       spike_in;
  logic [WIN_W-1:0]        win_len;
  logic [NUM_CH*CNT_W-1:0] count_out;
  logic [NUM_CH-1:0]       sat_out;
  logic                    count_valid;
  logic                    count_ready;
  logic                    overrun;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit                      m_run;
  int                      m_pos;
  int                      m_len;
  int                      m_ev[NUM_CH];
  bit [NUM_CH-1:0]         m_prev;
  logic [NUM_CH*CNT_W-1:0] m_cnt_out;
  logic [NUM_CH-1:0]       m_sat_out;
  bit                      m_valid;
  bit                      m_over;

  logic [9:0] mask0;
  logic [9:0] mask1;
  int         exp_v;

  spike_window_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .win_len(win_len),
    .count_out(count_out), .sat_out(sat_out), .count_valid(count_valid),
    .count_ready(count_ready), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    bit consume;
    bit evk;
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_len = 0; m_prev = '0;
      m_cnt_out = '0; m_sat_out = '0; m_valid = 1'b0; m_over = 1'b0;
      for (int k = 0; k < NUM_CH; k++) m_ev[k] = 0;
      return;
    end
    consume = m_valid && count_ready;
    if (!en) begin
      m_run = 1'b0;
      for (int k = 0; k < NUM_CH; k++) m_ev[k] = 0;
      if (consume) m_valid = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_pos = 0; m_len = int'(win_len);
      for (int k = 0; k < NUM_CH; k++) m_ev[k] = 0;
      if (consume) m_valid = 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        evk = spike_in[k];
`ifdef SPIKE_EDGE_DETECT_EN
        if (m_prev[k]) evk = 1'b0;
`endif
        if (evk) m_ev[k]++;
      end
      if (m_pos == m_len) begin
        for (int k = 0; k < NUM_CH; k++) begin
          m_cnt_out[k*CNT_W +: CNT_W] = CNT_W'((m_ev[k] > MAXC) ? MAXC : m_ev[k]);
          m_sat_out[k] = (m_ev[k] >= MAXC);
          m_ev[k] = 0;
        end
        if (m_valid && !count_ready) m_over = 1'b1;
        m_valid = 1'b1;
        m_pos = 0;
        m_len = int'(win_len);
      end else begin
        m_pos++;
        if (consume) m_valid = 1'b0;
      end
    end
    m_prev = spike_in;
  endtask

  // One clock: update model, clock the DUT, compare every output after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("count_out", 32'(count_out), 32'(m_cnt_out));
    check("sat_out", 32'(sat_out), 32'(m_sat_out));
    check("count_valid", 32'(count_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_over));
    check("busy", 32'(busy), 32'(m_run));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; spike_in = '0; win_len = '0; count_ready = 1'b0;
    cycle(); cycle();
    check("reset_valid", 32'(count_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(count_out), 32'd0);
    rst = 1'b0;

    // Basic count: ch0 3 pulses, ch1 7 high cycles in a 10-cycle window
    mask0 = 10'b0010010010;
    mask1 = 10'b1101010111;
    win_len = 8'd9; count_ready = 1'b1; en = 1'b1;
    cycle();
    for (int p = 0; p < 10; p++) begin
      spike_in = {mask1[p], mask0[p]};
      cycle();
    end
    spike_in = '0;
    check("basic_valid", 32'(count_valid), 32'd1);
`ifdef SPIKE_EDGE_DETECT_EN
    check("basic_count", 32'(count_out), 32'h0403);
`else
    check("basic_count", 32'(count_out), 32'h0703);
`endif
    check("basic_sat", 32'(sat_out), 32'd0);
    cycle();
    check("basic_valid_clear", 32'(count_valid), 32'd0);

    // Saturation: ch0 held high for a 256-cycle window
    en = 1'b0; cycle();
    win_len = 8'd255; en = 1'b1; cycle();
    spike_in = 2'b01;
    repeat (256) cycle();
    check("sat_valid", 32'(count_valid), 32'd1);
`ifdef SPIKE_EDGE_DETECT_EN
    check("sat_ch0", 32'(count_out[7:0]), 32'd1);
    check("sat_flag0", 32'(sat_out[0]), 32'd0);
`else
    check("sat_ch0", 32'(count_out[7:0]), 32'd255);
    check("sat_flag0", 32'(sat_out[0]), 32'd1);
`endif
    check("sat_ch1", 32'(count_out[15:8]), 32'd0);

    // Overrun: two windows with ready low
    spike_in = '0; en = 1'b0; cycle();
    win_len = 8'd3; count_ready = 1'b0; en = 1'b1; cycle();
    repeat (8) begin
      spike_in = NUM_CH'($urandom);
      cycle();
    end
    check("ovr_valid", 32'(count_valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    count_ready = 1'b1; spike_in = '0;
    cycle();
    check("ovr_consumed", 32'(count_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Boundary: ch0 on last/first cycles, ch1 4-cycle pulse straddling the boundary
    en = 1'b0; cycle();
    win_len = 8'd3; en = 1'b1; cycle();
    for (int p = 0; p < 8; p++) begin
      spike_in = {(p >= 2 && p <= 5) ? 1'b1 : 1'b0, (p == 3 || p == 4) ? 1'b1 : 1'b0};
      cycle();
      if (p == 3) begin
        check("bnd_w0_ch0", 32'(count_out[7:0]), 32'd1);
`ifdef SPIKE_EDGE_DETECT_EN
        check("bnd_w0_ch1", 32'(count_out[15:8]), 32'd1);
`else
        check("bnd_w0_ch1", 32'(count_out[15:8]), 32'd2);
`endif
      end
      if (p == 7) begin
`ifdef SPIKE_EDGE_DETECT_EN
        check("bnd_w1_ch0", 32'(count_out[7:0]), 32'd0);
        check("bnd_w1_ch1", 32'(count_out[15:8]), 32'd0);
`else
        check("bnd_w1_ch0", 32'(count_out[7:0]), 32'd1);
        check("bnd_w1_ch1", 32'(count_out[15:8]), 32'd2);
`endif
      end
    end

    // Abort with a pending result
    count_ready = 1'b0; spike_in = 2'b11;
    repeat (6) cycle();
    en = 1'b0;
    cycle();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid_kept", 32'(count_valid), 32'd1);
    cycle();
    check("abort_no_new", 32'(count_valid), 32'd1);
    check("pre_rst_overrun", 32'(overrun), 32'd1);

    // Reset with valid pending
    rst = 1'b1;
    cycle();
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_valid", 32'(count_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_sat", 32'(sat_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // win_len changes 4 -> 1 mid-window: one 5-cycle window then 2-cycle windows
    spike_in = '0; count_ready = 1'b1; win_len = 8'd4; en = 1'b1;
    cycle();
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) win_len = 8'd1;
      cycle();
      exp_v = (i == 5 || i == 7 || i == 9) ? 1 : 0;
      check("wl_valid", 32'(count_valid), 32'(exp_v));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      en          = ($urandom_range(0, 39) != 0);
      spike_in    = NUM_CH'($urandom);
      count_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) win_len = WIN_W'($urandom_range(0, 6));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
